// File: rtl/input_peripheral.sv
// Memory-mapped input peripheral: synchronises switches and buttons, debounces
// the buttons, latches press events (write-1-to-clear) and counts presses.
module input_peripheral #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        st_en_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic [16:0] io_sw_i,
    input  logic [3:0]  io_btn_i,
    output logic [31:0] ld_data_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [11:0]      ADDR_SW   = 12'h900;
    localparam logic [11:0]      ADDR_BTN  = 12'h910;
    localparam logic [11:0]      ADDR_EDGE = 12'h920;
    localparam logic [11:0]      ADDR_CNT  = 12'h930;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [16:0]      sw_sync1_q;
    logic [16:0]      sw_sync2_q;
    logic [3:0]       btn_sync1_q;
    logic [3:0]       btn_sync2_q;
    logic [3:0]       btn_press_s;
    logic [3:0]       btn_db_q;
    logic [3:0]       btn_db_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       press_s;
    logic [2:0]       press_num_s;
    logic [3:0]       edge_clr_s;
    logic [3:0]       edge_q;
    logic [3:0]       edge_d;
    logic [15:0]      press_cnt_q;
    logic [15:0]      press_cnt_d;
    logic             unused_s;

    assign unused_s    = ^st_data_i[31:4];
    assign btn_press_s = ~btn_sync2_q;

    // Two-flop synchronisers; buttons idle high (released)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_sync1_q  <= 17'd0;
            sw_sync2_q  <= 17'd0;
            btn_sync1_q <= 4'hF;
            btn_sync2_q <= 4'hF;
        end else begin
            sw_sync1_q  <= io_sw_i;
            sw_sync2_q  <= sw_sync1_q;
            btn_sync1_q <= io_btn_i;
            btn_sync2_q <= btn_sync1_q;
        end
    end

    // Debounce: a level is accepted after DEBOUNCE_CYCLES differing samples in a row
    always_comb begin
        btn_db_d = btn_db_q;
        press_s  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (btn_press_s[i] == btn_db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]    = CNT_ZERO;
                btn_db_d[i] = ~btn_db_q[i];
                press_s[i]  = ~btn_db_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Edge register (set beats clear) and press counter (store reloads with this cycle's presses)
    always_comb begin
        press_num_s = popcount4(press_s);
        if (st_en_i && (addr_i == ADDR_EDGE)) begin
            edge_clr_s = st_data_i[3:0];
        end else begin
            edge_clr_s = 4'b0000;
        end
        edge_d = (edge_q & ~edge_clr_s) | press_s;
        if (st_en_i && (addr_i == ADDR_CNT)) begin
            press_cnt_d = {13'd0, press_num_s};
        end else begin
            press_cnt_d = press_cnt_q + {13'd0, press_num_s};
        end
    end

    // State registers for debounce, events and counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_db_q    <= 4'b0000;
            edge_q      <= 4'b0000;
            press_cnt_q <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            btn_db_q    <= btn_db_d;
            edge_q      <= edge_d;
            press_cnt_q <= press_cnt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Combinational read mux
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (addr_i)
            ADDR_SW:   ld_data_o = {15'd0, sw_sync2_q};
            ADDR_BTN:  ld_data_o = {28'd0, btn_db_q};
            ADDR_EDGE: ld_data_o = {28'd0, edge_q};
            ADDR_CNT:  ld_data_o = {16'd0, press_cnt_q};
            default:   ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_input_peripheral.sv
// Bench for input_peripheral: history-window reference model checked every cycle,
// plus directed literal expectations for reset, debounce, W1C and counter cases.
module tb_input_peripheral;

    localparam int DEB = 4;

    logic        clk;
    logic        rst_n;
    logic        st_en_i;
    logic [11:0] addr_i;
    logic [31:0] st_data_i;
    logic [16:0] io_sw_i;
    logic [3:0]  io_btn_i;
    logic [31:0] ld_data_o;

    int          n_checks;
    int          n_fail;
    logic        lit_valid;
    logic [31:0] lit_exp;
    string       lit_name;
    logic        preload_req;

    input_peripheral #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .st_en_i   (st_en_i),
        .addr_i    (addr_i),
        .st_data_i (st_data_i),
        .io_sw_i   (io_sw_i),
        .io_btn_i  (io_btn_i),
        .ld_data_o (ld_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pins delayed two cycles; a button level flips once the last
    // DEB sampled values all disagree with the accepted level.
    logic [16:0]    m_sw1, m_sw2;
    logic [3:0]     m_btn1, m_btn2;
    logic [DEB-1:0] m_win [4];
    logic [DEB-1:0] m_win_n [4];
    logic [3:0]     m_db, m_db_n;
    logic [3:0]     m_edge, m_edge_n;
    logic [15:0]    m_cnt, m_cnt_n;
    logic [3:0]     m_pmask;
    logic [3:0]     m_clr;
    int             m_npress;

    always_comb begin
        m_db_n   = m_db;
        m_pmask  = 4'b0000;
        m_npress = 0;
        for (int i = 0; i < 4; i++) begin
            m_win_n[i] = {m_win[i][DEB-2:0], ~m_btn2[i]};
            if (m_win_n[i] == {DEB{~m_db[i]}}) begin
                m_db_n[i] = ~m_db[i];
                if (!m_db[i]) begin
                    m_pmask[i] = 1'b1;
                    m_npress   = m_npress + 1;
                end
            end
        end
        m_clr    = (st_en_i && addr_i == 12'h920) ? st_data_i[3:0] : 4'b0000;
        m_edge_n = (m_edge & ~m_clr) | m_pmask;
        if (preload_req) m_cnt_n = 16'hFFFF;
        else if (st_en_i && addr_i == 12'h930) m_cnt_n = 16'(m_npress);
        else m_cnt_n = m_cnt + 16'(m_npress);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sw1  <= 17'd0;
            m_sw2  <= 17'd0;
            m_btn1 <= 4'hF;
            m_btn2 <= 4'hF;
            m_db   <= 4'h0;
            m_edge <= 4'h0;
            m_cnt  <= 16'd0;
            for (int i = 0; i < 4; i++) m_win[i] <= '0;
        end else begin
            m_sw1  <= io_sw_i;
            m_sw2  <= m_sw1;
            m_btn1 <= io_btn_i;
            m_btn2 <= m_btn1;
            m_db   <= m_db_n;
            m_edge <= m_edge_n;
            m_cnt  <= m_cnt_n;
            for (int i = 0; i < 4; i++) m_win[i] <= m_win_n[i];
        end
    end

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h900: model_read = {15'd0, m_sw2};
            12'h910: model_read = {28'd0, m_db};
            12'h920: model_read = {28'd0, m_edge};
            12'h930: model_read = {16'd0, m_cnt};
            default: model_read = 32'd0;
        endcase
    endfunction

    // Single compare process, sampling mid-cycle
    always @(negedge clk) begin
        n_checks = n_checks + 1;
        if (ld_data_o !== model_read(addr_i)) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp t=%0t addr=%h got=%h exp=%h", $time, addr_i, ld_data_o, model_read(addr_i));
        end
        if (lit_valid) begin
            n_checks = n_checks + 1;
            if (ld_data_o !== lit_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s t=%0t addr=%h got=%h exp=%h", lit_name, $time, addr_i, ld_data_o, lit_exp);
            end
        end
    end

    task automatic cyc(input logic [11:0] a, input logic st, input logic [31:0] d,
                       input logic chk, input logic [31:0] exp, input string name);
        addr_i    = a;
        st_en_i   = st;
        st_data_i = d;
        lit_valid = chk;
        lit_exp   = exp;
        lit_name  = name;
        @(posedge clk);
        #1;
        st_en_i   = 1'b0;
        lit_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic [11:0] a);
        for (int k = 0; k < n; k++) cyc(a, 1'b0, 32'd0, 1'b0, 32'd0, "");
    endtask

    task automatic hold_btn(input logic [3:0] b, input int n, input logic [11:0] a);
        io_btn_i = b;
        idle(n, a);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        lit_valid   = 1'b0;
        lit_exp     = 32'd0;
        lit_name    = "";
        preload_req = 1'b0;
        rst_n       = 1'b0;
        st_en_i     = 1'b0;
        addr_i      = 12'h900;
        st_data_i   = 32'd0;
        io_sw_i     = 17'h1ABCD;
        io_btn_i    = 4'hF;
        @(posedge clk);
        #1;

        // Reset: every address reads 0
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'd0, "rst_sw");
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "rst_btn");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd0, "rst_edge");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd0, "rst_cnt");
        rst_n = 1'b1;
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'd0, "sw_pre_e1");
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'd0, "sw_after_e1");
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'h0001ABCD, "sw_after_e2");
        io_sw_i = 17'h00F0F;
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'h0001ABCD, "sw_chg_e0");
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'h0001ABCD, "sw_chg_e1");
        cyc(12'h900, 1'b0, 32'd0, 1'b1, 32'h00000F0F, "sw_chg_e2");

        // Clean press on button 0: visible after edge 5, not before
        io_btn_i = 4'hE;
        for (int k = 0; k < 6; k++) cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "press_early");
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd1, "press_db");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd1, "press_edge");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd1, "press_cnt");
        hold_btn(4'hF, 8, 12'h910);
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "release_db");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd1, "release_cnt");
        cyc(12'h930, 1'b1, 32'd0, 1'b0, 32'd0, "");
        cyc(12'h920, 1'b1, 32'hF, 1'b0, 32'd0, "");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd0, "clr_cnt");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd0, "clr_edge");

        // Bounce on button 1: 3 low, 1 high, 3 low
        io_btn_i = 4'hD;
        for (int k = 0; k < 3; k++) cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "bounce_db");
        io_btn_i = 4'hF;
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd0, "bounce_cnt");
        io_btn_i = 4'hD;
        for (int k = 0; k < 3; k++) cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "bounce_db");
        io_btn_i = 4'hF;
        for (int k = 0; k < 4; k++) cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "bounce_db");
        for (int k = 0; k < 4; k++) cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd0, "bounce_cnt");

        // Clean 6-cycle pulse on button 1: exactly one event
        hold_btn(4'hD, 6, 12'h900);
        io_btn_i = 4'hF;
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd2, "pulse_db");
        idle(8, 12'h910);
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd2, "pulse_edge");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd1, "pulse_cnt");

        // Write-1-to-clear, then set beats clear in the same cycle
        hold_btn(4'hE, 6, 12'h900);
        hold_btn(4'hF, 8, 12'h900);
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd3, "w1c_pre");
        cyc(12'h920, 1'b1, 32'd1, 1'b0, 32'd0, "");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd2, "w1c_clr");
        hold_btn(4'hD, 5, 12'h900);
        cyc(12'h920, 1'b1, 32'd2, 1'b0, 32'd0, "");
        io_btn_i = 4'hF;
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd2, "set_wins");
        idle(8, 12'h900);

        // Counter wrap from 0xFFFF
        addr_i      = 12'h900;
        preload_req = 1'b1;
        force dut.press_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.press_cnt_q;
        preload_req = 1'b0;
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'h0000FFFF, "preload");
        hold_btn(4'hB, 6, 12'h900);
        io_btn_i = 4'hF;
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd0, "wrap");
        idle(8, 12'h900);

        // Store to counter coinciding with two press events
        hold_btn(4'h6, 5, 12'h900);
        cyc(12'h930, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, "");
        io_btn_i = 4'hF;
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd2, "clr_plus_two");
        idle(8, 12'h900);

        // Unmapped and read-only stores change nothing
        cyc(12'h940, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd0, "unmapped_rd");
        cyc(12'h900, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0, "");
        cyc(12'h910, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0, "");
        cyc(12'h940, 1'b0, 32'd0, 1'b1, 32'd0, "unmapped_rd2");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'hF, "unmapped_edge");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd2, "unmapped_cnt");

        // Reset mid-debounce: held button is re-debounced from scratch
        hold_btn(4'hE, 4, 12'h910);
        rst_n = 1'b0;
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "midrst_db");
        cyc(12'h920, 1'b0, 32'd0, 1'b1, 32'd0, "midrst_edge");
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd0, "midrst_early");
        cyc(12'h910, 1'b0, 32'd0, 1'b1, 32'd1, "midrst_db_late");
        cyc(12'h930, 1'b0, 32'd0, 1'b1, 32'd1, "midrst_cnt");
        hold_btn(4'hF, 8, 12'h910);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_peripheral.md
# input_peripheral

Memory-mapped input peripheral for the MEM stage: samples board switches and push-buttons and returns them on the load-data path. It is the read-side counterpart of the LED/HEX/LCD output block and shares the same 12-bit address decode and `st_en_i` store strobe. It synchronises raw pins, debounces the buttons, latches press events in a sticky write-1-to-clear register, and counts presses.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles a synchronised button level must hold before it is accepted. Must be ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `st_en_i`  in  1  store strobe from the LSU.
- `addr_i`  in  12  word address within the IO window.
- `st_data_i`  in  32  store data.
- `io_sw_i`  in  17  raw slide switches, active-high, asynchronous to `clk_i`.
- `io_btn_i`  in  4  raw push-buttons, active-low (pressed = 0), asynchronous to `clk_i`.
- `ld_data_o`  out  32  combinational read data for `addr_i`.

## Operation
- **Synchroniser:** two-flop synchroniser on every switch and button bit.
  - Switch stages reset to 0.
  - Button stages reset to 1 (released).
  - `btn_press` = inverted second-stage button value (1 = pressed).
- **Debounce, per button i:**
  - Accepted level `btn_db[i]` resets to 0. Counter `cnt[i]` resets to 0.
  - If `btn_press[i] == btn_db[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `btn_db[i]` toggles and `cnt[i] <= 0`.
  - Else: `cnt[i]` increments.
  - Any glitch back to the accepted level restarts the count.
- **Press event:** `press[i]` is 1 in the cycle where `btn_db[i]` is about to go 0→1. Releases generate no event.
- **Edge register `edge[3:0]`:** resets to 0.
  - Each press event sets its bit.
  - A store (`st_en_i & addr_i==12'h920`) clears bits where `st_data_i[3:0]` is 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Press counter `press_cnt[15:0]`:** resets to 0.
  - Adds popcount(`press`) each cycle (0..4).
  - Wraps modulo 2^16 (0xFFFF + 1 → 0x0000).
  - A store to 12'h930 (any data) loads popcount(`press`) of that cycle, so a clear and a press in the same cycle gives 1.
- **Read map (`ld_data_o`, combinational, independent of `st_en_i`):**
  - 12'h900 → {15'd0, switch sync stage 2}.
  - 12'h910 → {28'd0, `btn_db`}.
  - 12'h920 → {28'd0, `edge`}.
  - 12'h930 → {16'd0, `press_cnt`}.
  - any other address → 32'd0.
- Stores to 12'h900 and 12'h910 are ignored. Stores outside the map have no effect.

## Timing
- **Reset values:** `ld_data_o` = 0 for every address. All internal state takes the reset values listed above, asynchronously on `rst_ni` low.
- **Reset mid-debounce:** the counter is discarded and `btn_db` returns to 0. After reset is released, a held button must be re-debounced from scratch.
- **Switch latency:** a pin change before edge N is visible at 0x900 after edge N+1 (two flops).
- **Button latency:** a clean press changing the pin before edge N gives `btn_press` = 1 after edge N+1. `btn_db`, `edge` and `press_cnt` then update together at edge N+1+`DEBOUNCE_CYCLES`.
- **Release latency:** same as press latency; `btn_db` falls with no change to `edge` or `press_cnt`.
- **Stores:** clear/load effects on `edge` and `press_cnt` take effect at the clock edge that samples `st_en_i`=1 and are visible to a read in the following cycle.
- **Reads:** same cycle as `addr_i` (no register on the output). No wait states, no handshake.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4.
- **Reset and switches:** assert `rst_ni` low with `io_btn_i` = 4'hF and `io_sw_i` = 17'h1ABCD.
  - During reset, all four addresses read 0.
  - After release, 0x900 reads 0x0001ABCD from the 2nd cycle onward.
- **Clean press:** hold `io_btn_i` = 4'hE from edge 0.
  - 0x910 reads 0x1, 0x920 reads 0x1 and 0x930 reads 0x1 starting after edge 5; not before.
- **Bounce:** drive `io_btn_i[1]` low 3 cycles, high 1 cycle, low 3 cycles, high.
  - 0x910 stays 0 and 0x930 stays 0 throughout.
  - A following 6-cycle low pulse produces exactly one event: 0x920 = 0x2.
- **Write-1-to-clear:** with 0x920 = 0x3, store 0x1 to 0x920 → reads 0x2. Then make a press event on button 1 coincide with a store of 0x2 to 0x920 → reads 0x2 (set wins).
- **Counter wrap and clear:**
  - Preload by 65535 presses (or force), then one more press → 0x930 reads 0x0000.
  - Store to 0x930 in the same cycle as two simultaneous press events → reads 0x0002.
  - Store to unmapped 0x940 → no register changes; read of 0x940 returns 0.
